id_ex_issue_reg: RTL and testbench

Parametrised decode-to-execute pipeline register with integrated operand forwarding. It sits between the decode stage and the execute stage. It replaces the fixed two-operand, bubble-only ID/EX latch with:
- NUM_SRC operand slots, each selecting from NUM_FWD bypass sources.
- A hold mode that freezes the issued instruction while the execute stage is busy (mult/div), as distinct from stall, which inserts a bubble.
- Per-slot operand refresh while held.

---
 rtl/id_ex_issue_reg.sv | 135 +++++++++++++
 tb/tb_id_ex_issue_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue_reg.sv
// ID/EX pipeline register with per-slot operand forwarding: 1-cycle latency, opnd is combinational.
// hold freezes the issued op (optional slot refresh), stall loads a bubble; optional counters via ID_EX_ISSUE_PERF_EN.
module id_ex_issue_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TYPE_W  = 60,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter logic [TYPE_W-1:0] NOP_TYPE = TYPE_W'(1),
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0000_3000),
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'h1234_ABCD),
  localparam int SEL_W = (NUM_FWD > 0) ? $clog2(NUM_FWD + 1) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [TYPE_W-1:0]         in_type,
  input  logic [ADDR_W-1:0]         in_waddr,
  input  logic [NUM_SRC*ADDR_W-1:0] in_raddr,
  input  logic [NUM_SRC*DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [NUM_SRC*3-1:0]      in_tuse,
  input  logic [2:0]                in_tnew,
  input  logic                      in_err,
  input  logic [4:0]                in_exccode,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  input  logic                      stall,
  input  logic                      hold,
  input  logic [NUM_SRC-1:0]        hold_refresh,
  input  logic                      flush,
  input  logic                      eret,
  output logic [NUM_SRC*DATA_W-1:0] opnd,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_pc,
  output logic [TYPE_W-1:0]         out_type,
  output logic [ADDR_W-1:0]         out_waddr,
  output logic [NUM_SRC*ADDR_W-1:0] out_raddr,
  output logic [NUM_SRC*DATA_W-1:0] out_rdata,
  output logic [DATA_W-1:0]         out_imm,
  output logic [NUM_SRC*3-1:0]      out_tuse,
  output logic [2:0]                out_tnew,
  output logic                      out_err,
  output logic [4:0]                out_exccode
`ifdef ID_EX_ISSUE_PERF_EN
  ,
  output logic [31:0]               perf_bubbles,
  output logic [31:0]               perf_holds
`endif
);

  localparam logic [NUM_SRC*3-1:0] TUSE_IDLE = {NUM_SRC{3'b111}};
  localparam logic [4:0]           EXC_NONE  = 5'd31;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mux;

    assign sel = fwd_sel[k*SEL_W +: SEL_W];

    // Selects beyond the last bypass source read as ERR_WORD so bad decode is visible downstream.
    always_comb begin
      mux = ERR_WORD;
      if (sel == '0) mux = in_rdata[k*DATA_W +: DATA_W];
      for (int j = 0; j < NUM_FWD; j++) begin
        if (sel == SEL_W'(j + 1)) mux = fwd_data[j*DATA_W +: DATA_W];
      end
    end

    assign opnd[k*DATA_W +: DATA_W] = mux;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush || eret) begin
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_type    <= NOP_TYPE;
      out_waddr   <= '0;
      out_raddr   <= '0;
      out_rdata   <= '0;
      out_imm     <= '0;
      out_tuse    <= TUSE_IDLE;
      out_tnew    <= '0;
      out_err     <= 1'b0;
      out_exccode <= EXC_NONE;
    end else if (hold) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (hold_refresh[k]) out_rdata[k*DATA_W +: DATA_W] <= opnd[k*DATA_W +: DATA_W];
      end
    end else if (stall) begin
      // out_pc is kept so a fault in the bubble slot is still attributed to the last issued PC.
      out_valid   <= 1'b0;
      out_type    <= NOP_TYPE;
      out_waddr   <= '0;
      out_raddr   <= '0;
      out_rdata   <= '0;
      out_imm     <= '0;
      out_tuse    <= TUSE_IDLE;
      out_tnew    <= '0;
      out_err     <= 1'b0;
      out_exccode <= EXC_NONE;
    end else begin
      out_valid   <= in_valid;
      out_pc      <= in_pc;
      out_type    <= in_valid ? in_type : NOP_TYPE;
      out_waddr   <= in_waddr;
      out_raddr   <= in_raddr;
      out_rdata   <= opnd;
      out_imm     <= in_imm;
      out_tuse    <= in_tuse;
      out_tnew    <= in_tnew;
      out_err     <= in_err;
      out_exccode <= in_exccode;
    end
  end

`ifdef ID_EX_ISSUE_PERF_EN
  logic bubble_edge, hold_edge;

  assign bubble_edge = flush || eret || (stall && !hold);
  assign hold_edge   = hold && !flush && !eret;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_bubbles <= '0;
      perf_holds   <= '0;
    end else begin
      if (bubble_edge) perf_bubbles <= perf_bubbles + 32'd1;
      if (hold_edge)   perf_holds   <= perf_holds + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_issue_reg.sv
// Directed plus randomized bench for id_ex_issue_reg against a behavioural reference model.
module tb_id_ex_issue_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 60;
  localparam int NS = 2;
  localparam int NF = 2;
  localparam int SW = 2;
  localparam logic [TW-1:0] NOP  = 60'h1;
  localparam logic [DW-1:0] RPC  = 32'h0000_3000;
  localparam logic [DW-1:0] ERRW = 32'h1234_ABCD;

  logic clk;
  logic reset;
  logic in_valid;
  logic [DW-1:0] in_pc;
  logic [TW-1:0] in_type;
  logic [AW-1:0] in_waddr;
  logic [NS*AW-1:0] in_raddr;
  logic [NS*DW-1:0] in_rdata;
  logic [DW-1:0] in_imm;
  logic [NS*3-1:0] in_tuse;
  logic [2:0] in_tnew;
  logic in_err;
  logic [4:0] in_exccode;
  logic [NF*DW-1:0] fwd_data;
  logic [NS*SW-1:0] fwd_sel;
  logic stall, hold, flush, eret;
  logic [NS-1:0] hold_refresh;
  logic [NS*DW-1:0] opnd;
  logic out_valid;
  logic [DW-1:0] out_pc;
  logic [TW-1:0] out_type;
  logic [AW-1:0] out_waddr;
  logic [NS*AW-1:0] out_raddr;
  logic [NS*DW-1:0] out_rdata;
  logic [DW-1:0] out_imm;
  logic [NS*3-1:0] out_tuse;
  logic [2:0] out_tnew;
  logic out_err;
  logic [4:0] out_exccode;

  // Reference model state
  logic m_valid;
  logic [DW-1:0] m_pc;
  logic [TW-1:0] m_type;
  logic [AW-1:0] m_waddr;
  logic [NS*AW-1:0] m_raddr;
  logic [DW-1:0] m_rdata [NS];
  logic [DW-1:0] m_imm;
  logic [NS*3-1:0] m_tuse;
  logic [2:0] m_tnew;
  logic m_err;
  logic [4:0] m_exccode;

  int n_chk = 0;
  int n_pass = 0;

  id_ex_issue_reg #(.NUM_FWD(NF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_type(in_type),
    .in_waddr(in_waddr), .in_raddr(in_raddr), .in_rdata(in_rdata), .in_imm(in_imm),
    .in_tuse(in_tuse), .in_tnew(in_tnew), .in_err(in_err), .in_exccode(in_exccode),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .hold(hold),
    .hold_refresh(hold_refresh), .flush(flush), .eret(eret), .opnd(opnd),
    .out_valid(out_valid), .out_pc(out_pc), .out_type(out_type), .out_waddr(out_waddr),
    .out_raddr(out_raddr), .out_rdata(out_rdata), .out_imm(out_imm), .out_tuse(out_tuse),
    .out_tnew(out_tnew), .out_err(out_err), .out_exccode(out_exccode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Operand value for slot k, straight from the select rule.
  function automatic logic [DW-1:0] ref_opnd(input int k);
    int s;
    s = int'(fwd_sel[k*SW +: SW]);
    if (s == 0) return in_rdata[k*DW +: DW];
    if (s <= NF) return fwd_data[(s-1)*DW +: DW];
    return ERRW;
  endfunction

  function automatic logic [NS*DW-1:0] ref_opnd_all();
    logic [NS*DW-1:0] v;
    for (int k = 0; k < NS; k++) v[k*DW +: DW] = ref_opnd(k);
    return v;
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_type = NOP; m_waddr = '0; m_raddr = '0; m_imm = '0;
    for (int k = 0; k < NS; k++) m_rdata[k] = '0;
    m_tuse = 6'h3F; m_tnew = '0; m_err = 1'b0; m_exccode = 5'd31;
  endtask

  task automatic model_edge();
    if (!reset || flush || eret) begin
      model_bubble();
      m_pc = RPC;
    end else if (hold) begin
      for (int k = 0; k < NS; k++) if (hold_refresh[k]) m_rdata[k] = ref_opnd(k);
    end else if (stall) begin
      model_bubble();
    end else begin
      m_valid = in_valid; m_pc = in_pc; m_type = in_valid ? in_type : NOP;
      m_waddr = in_waddr; m_raddr = in_raddr; m_imm = in_imm;
      for (int k = 0; k < NS; k++) m_rdata[k] = ref_opnd(k);
      m_tuse = in_tuse; m_tnew = in_tnew; m_err = in_err; m_exccode = in_exccode;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_pc", out_pc, m_pc);
    chk("out_type", out_type, m_type);
    chk("out_waddr", out_waddr, m_waddr);
    chk("out_raddr", out_raddr, m_raddr);
    chk("out_rdata", out_rdata, {m_rdata[1], m_rdata[0]});
    chk("out_imm", out_imm, m_imm);
    chk("out_tuse", out_tuse, m_tuse);
    chk("out_tnew", out_tnew, m_tnew);
    chk("out_err", out_err, m_err);
    chk("out_exccode", out_exccode, m_exccode);
  endtask

  task automatic step();
    #1 chk("opnd", opnd, ref_opnd_all());
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); in_pc = $urandom; in_type = {28'($urandom), $urandom};
    in_waddr = 5'($urandom); in_raddr = 10'($urandom);
    in_rdata = {$urandom, $urandom}; in_imm = $urandom;
    in_tuse = 6'($urandom); in_tnew = 3'($urandom); in_err = 1'($urandom);
    in_exccode = 5'($urandom); fwd_data = {$urandom, $urandom}; fwd_sel = 4'($urandom);
  endtask

  task automatic ctrl_idle();
    reset = 1'b1; stall = 1'b0; hold = 1'b0; flush = 1'b0; eret = 1'b0; hold_refresh = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_idle();
    rand_inputs();
    reset = 1'b0;
    step();
    rand_inputs(); hold = 1'b1; stall = 1'b1;
    step();
    chk("rst_pc", out_pc, RPC);
    chk("rst_type", out_type, NOP);
    chk("rst_tuse", out_tuse, 6'h3F);
    chk("rst_exccode", out_exccode, 5'd31);
    chk("rst_valid", out_valid, 1'b0);

    // Forwarding from source 1, and out-of-range select
    ctrl_idle(); rand_inputs(); in_valid = 1'b1;
    in_rdata = {32'h22, 32'h11}; fwd_data = {32'hAB, 32'hCD}; fwd_sel = {2'd3, 2'd2};
    #1 chk("fwd_opnd0", opnd[31:0], 32'hAB);
    chk("fwd_opnd1_err", opnd[63:32], ERRW);
    step();
    chk("fwd_rdata0", out_rdata[31:0], 32'hAB);
    chk("fwd_rdata1_err", out_rdata[63:32], ERRW);

    // Stall keeps PC, bubbles everything else
    rand_inputs(); in_valid = 1'b1; in_pc = 32'h3010;
    step();
    rand_inputs(); in_pc = 32'h3014; stall = 1'b1;
    step();
    chk("stall_pc", out_pc, 32'h3010);
    chk("stall_valid", out_valid, 1'b0);
    chk("stall_type", out_type, NOP);

    // Hold for three cycles with slot-1 refresh in the second
    ctrl_idle(); rand_inputs(); in_valid = 1'b1; in_pc = 32'h3020;
    in_rdata = {32'd5, 32'h77}; fwd_sel = 4'b0000;
    step();
    rand_inputs(); hold = 1'b1;
    step();
    chk("hold1_pc", out_pc, 32'h3020);
    chk("hold1_rdata1", out_rdata[63:32], 32'd5);
    rand_inputs(); hold_refresh = 2'b10; in_rdata[63:32] = 32'd9; fwd_sel[3:2] = 2'd0;
    step();
    chk("hold2_rdata1", out_rdata[63:32], 32'd9);
    chk("hold2_rdata0", out_rdata[31:0], 32'h77);
    rand_inputs(); hold_refresh = 2'b00; stall = 1'b1;
    step();
    chk("hold3_pc", out_pc, 32'h3020);
    chk("hold3_valid", out_valid, 1'b1);
    chk("hold3_rdata1", out_rdata[63:32], 32'd9);

    // Flush overrides hold; eret alone behaves the same
    rand_inputs(); stall = 1'b0; flush = 1'b1;
    step();
    chk("flush_hold_pc", out_pc, RPC);
    chk("flush_hold_valid", out_valid, 1'b0);
    ctrl_idle(); rand_inputs(); in_valid = 1'b1; in_pc = 32'h3040;
    step();
    rand_inputs(); eret = 1'b1;
    step();
    chk("eret_pc", out_pc, RPC);

    // Exception pass-through then cleared by stall
    ctrl_idle(); rand_inputs(); in_valid = 1'b1; in_err = 1'b1; in_exccode = 5'd10;
    step();
    chk("exc_err", out_err, 1'b1);
    chk("exc_code", out_exccode, 5'd10);
    rand_inputs(); stall = 1'b1;
    step();
    chk("exc_stall_err", out_err, 1'b0);
    chk("exc_stall_code", out_exccode, 5'd31);

    // Invalid load forces NOP type
    ctrl_idle(); rand_inputs(); in_valid = 1'b0; in_type = 60'hFFF0;
    step();
    chk("invalid_type", out_type, NOP);

    // Reset asserted mid-hold
    rand_inputs(); in_valid = 1'b1; in_pc = 32'h3050;
    step();
    rand_inputs(); hold = 1'b1; reset = 1'b0;
    step();
    chk("rst_hold_pc", out_pc, RPC);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      reset        = ($urandom_range(0, 31) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      eret         = ($urandom_range(0, 15) == 0);
      hold         = ($urandom_range(0, 3) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      hold_refresh = 2'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
